// File: rtl/bp_me_stream_pump_out.sv
// Outbound BedRock stream pump: turns producer FSM beats into a buffered
// mem-side stream with wrap-around beat addressing and 1:1, 1:N or N:1 conversion.
package bp_me_stream_pump_out_pkg;
    localparam int unsigned paddr_width_gp    = 40;
    localparam int unsigned msg_type_width_gp = 4;
    localparam int unsigned msg_size_width_gp = 3;
    localparam int unsigned msg_types_gp      = 1 << msg_type_width_gp;

    typedef struct packed {
        logic [msg_type_width_gp-1:0] msg_type;
        logic [msg_size_width_gp-1:0] size;
        logic [paddr_width_gp-1:0]    addr;
    } bp_mem_msg_header_s;
endpackage

module bp_me_stream_pump_out
    import bp_me_stream_pump_out_pkg::*;
#(
    parameter int unsigned             stream_data_width_p = 64,
    parameter int unsigned             block_width_p       = 512,
    parameter logic [msg_types_gp-1:0] mem_stream_mask_p   = '0,
    parameter logic [msg_types_gp-1:0] fsm_stream_mask_p   = mem_stream_mask_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  bp_mem_msg_header_s             fsm_base_header_i,
    input  logic [stream_data_width_p-1:0] fsm_data_i,
    input  logic                           fsm_v_i,
    output logic                           fsm_yumi_o,
    output logic [paddr_width_gp-1:0]      fsm_addr_o,
    output logic                           fsm_new_o,
    output logic                           fsm_critical_o,
    output logic                           fsm_last_o,
    output bp_mem_msg_header_s             mem_header_o,
    output logic [stream_data_width_p-1:0] mem_data_o,
    output logic                           mem_v_o,
    output logic                           mem_last_o,
    input  logic                           mem_ready_and_i
);
    localparam int unsigned stream_offset_lp = $clog2(stream_data_width_p / 8);
    localparam int unsigned ratio_lp         = block_width_p / stream_data_width_p;
    localparam int unsigned cnt_w_lp         = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int unsigned block_offset_lp  = $clog2(block_width_p / 8);
    localparam int unsigned size_bytes_w_lp  = 1 << msg_size_width_gp;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                     state_q, state_d;
    logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
    logic [block_offset_lp-1:0] crit_q, crit_d;

    logic [size_bytes_w_lp-1:0] size_bytes, beats_raw;
    logic                       multi_beat, is_fsm_stream, is_mem_stream, is_stream;
    logic [cnt_w_lp-1:0]        num_beats_m1, addr_cnt, stream_cnt, last_cnt;
    logic                       is_last_cnt, fifo_ready, enq, deq, enq_last, cnt_up, done;
    bp_mem_msg_header_s         enq_hdr;

    // Message geometry derived from the held header
    assign size_bytes    = size_bytes_w_lp'(1) << fsm_base_header_i.size;
    assign beats_raw     = size_bytes >> stream_offset_lp;
    assign multi_beat    = beats_raw > size_bytes_w_lp'(1);
    assign num_beats_m1  = multi_beat ? cnt_w_lp'(beats_raw - size_bytes_w_lp'(1)) : '0;
    assign is_fsm_stream = fsm_stream_mask_p[fsm_base_header_i.msg_type] & multi_beat;
    assign is_mem_stream = mem_stream_mask_p[fsm_base_header_i.msg_type] & multi_beat;
    assign is_stream     = is_fsm_stream | is_mem_stream;

    assign addr_cnt    = fsm_base_header_i.addr[stream_offset_lp +: cnt_w_lp];
    assign stream_cnt  = (state_q == IDLE) ? addr_cnt : cnt_q;
    assign last_cnt    = addr_cnt + num_beats_m1;
    assign is_last_cnt = ~is_stream | (stream_cnt == last_cnt);

    // Count field wraps inside the naturally aligned size window
    always_comb begin
        fsm_addr_o = fsm_base_header_i.addr;
        fsm_addr_o[stream_offset_lp +: cnt_w_lp] = (stream_cnt & num_beats_m1)
                                                 | (addr_cnt & ~num_beats_m1);
    end

    assign fsm_new_o      = is_stream & (state_q == IDLE) & fsm_v_i;
    assign fsm_critical_o = (state_q == IDLE);
    assign fsm_last_o     = is_last_cnt;

    // Beat conversion: decide enqueue, consume and count advance
    always_comb begin
        enq        = 1'b0;
        fsm_yumi_o = 1'b0;
        cnt_up     = 1'b0;
        enq_last   = is_last_cnt;
        if (is_mem_stream & ~is_fsm_stream) begin
            enq        = fsm_v_i & fifo_ready;
            fsm_yumi_o = enq & is_last_cnt;
            cnt_up     = enq;
        end else if (is_fsm_stream & ~is_mem_stream) begin
            enq        = fsm_v_i & fifo_ready & is_last_cnt;
            fsm_yumi_o = fsm_v_i & (~is_last_cnt | fifo_ready);
            cnt_up     = fsm_yumi_o;
            enq_last   = 1'b1;
        end else begin
            enq        = fsm_v_i & fifo_ready;
            fsm_yumi_o = enq;
            cnt_up     = enq & is_stream;
        end
    end

    assign done = cnt_up & is_last_cnt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crit_d  = crit_q;
        if (state_q == IDLE) crit_d = fsm_base_header_i.addr[block_offset_lp-1:0];
        if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cnt_up) begin
            if (state_q == IDLE) begin
                state_d = STREAM;
                cnt_d   = addr_cnt + cnt_w_lp'(1);
            end else begin
                cnt_d = cnt_q + cnt_w_lp'(1);
            end
        end
    end

    always_comb begin
        enq_hdr = fsm_base_header_i;
        enq_hdr.addr[block_offset_lp-1:0] = (state_q == STREAM) ? crit_q
                                          : fsm_base_header_i.addr[block_offset_lp-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crit_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crit_q  <= crit_d;
        end
    end

    // Two-entry output FIFO decoupling mem backpressure from the producer
    logic [1:0]                     fifo_cnt_q;
    logic                           wr_ptr_q, rd_ptr_q;
    bp_mem_msg_header_s             fifo_hdr_q  [2];
    logic [stream_data_width_p-1:0] fifo_data_q [2];
    logic [1:0]                     fifo_last_q;

    assign fifo_ready   = (fifo_cnt_q != 2'd2);
    assign mem_v_o      = (fifo_cnt_q != 2'd0);
    assign deq          = mem_v_o & mem_ready_and_i;
    assign mem_header_o = fifo_hdr_q[rd_ptr_q];
    assign mem_data_o   = fifo_data_q[rd_ptr_q];
    assign mem_last_o   = mem_v_o & fifo_last_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_last_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_hdr_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                fifo_hdr_q[wr_ptr_q]  <= enq_hdr;
                fifo_data_q[wr_ptr_q] <= fsm_data_i;
                fifo_last_q[wr_ptr_q] <= enq_last;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (deq) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(enq) - 2'(deq);
        end
    end

    // The producer must hold the header for the whole message
    hdr_stable_a: assert property (@(posedge clk_i) disable iff (!reset_i)
        (state_q == STREAM) |-> $stable(fsm_base_header_i));

endmodule
